// File: rtl/layer_y_rx_15_16.sv
// layer_y_rx_15_16: receiving end of a layer's y sample stream.
// Collects LEN signed samples into a frame buffer and then holds the frame
// until the consumer releases it. While collecting, it tracks the running
// signed maximum and its index. The buffer can be read at any time through
// a registered read port.
//
// Handshake: a sample transfers on a rising edge where s_valid_y=1 and
// s_ready_y=1. s_ready_y depends only on the FSM state, never on s_valid_y.
// The upstream block keeps its sample stable while it is not accepted.
//
// The consumer's release input is named frame_release because "release" is a
// reserved word in SystemVerilog. state_dbg exposes the FSM state for checkers
// (0 = FILL, 1 = HOLD).
module layer_y_rx_15_16 #(
  parameter int WIDTH = 16,
  parameter int LEN   = 15,
  parameter int ADDR  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in_y,
  input  logic                    s_valid_y,
  output logic                    s_ready_y,
  input  logic        [ADDR-1:0]  rd_addr,
  output logic signed [WIDTH-1:0] rd_data,
  output logic                    frame_valid,
  output logic                    frame_done,
  output logic signed [WIDTH-1:0] max_val,
  output logic        [ADDR-1:0]  max_idx,
  input  logic                    frame_release,
  output logic                    state_dbg
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int DEPTH = 1 << ADDR;
  localparam logic [ADDR-1:0] LAST_IDX = ADDR'(LEN - 1);
  localparam logic [ADDR:0]   LEN_EXT  = (ADDR + 1)'(LEN);

  state_e state_q, state_d;
  logic [ADDR-1:0] idx_q;
  logic signed [WIDTH-1:0] buf_mem [0:DEPTH-1];
  logic xfer;
  logic last_xfer;

  assign xfer      = s_valid_y & s_ready_y;
  assign last_xfer = xfer & (idx_q == LAST_IDX);
  assign state_dbg = state_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FILL;
    else        state_q <= state_d;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d     = state_q;
    s_ready_y   = 1'b0;
    frame_valid = 1'b0;
    case (state_q)
      FILL: begin
        s_ready_y = 1'b1;
        if (last_xfer) state_d = HOLD;
      end
      HOLD: begin
        frame_valid = 1'b1;
        if (frame_release) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Write index: advances on each transfer and wraps when the frame completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
    end else if (xfer) begin
      if (last_xfer) idx_q <= '0;
      else           idx_q <= idx_q + 1'b1;
    end
  end

  // One-cycle pulse in the first HOLD cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_done <= 1'b0;
    else        frame_done <= last_xfer;
  end

  // Running maximum: index 0 loads unconditionally, later samples replace
  // only when strictly greater so ties keep the lowest index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (xfer) begin
      if ((idx_q == '0) || (s_data_in_y > max_val)) begin
        max_val <= s_data_in_y;
        max_idx <= idx_q;
      end
    end
  end

  // Frame buffer storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (xfer) buf_mem[idx_q] <= s_data_in_y;
  end

  // Registered read port; out-of-frame addresses read as zero. A read of the
  // address being written this cycle returns the previous contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if ({1'b0, rd_addr} < LEN_EXT) begin
      rd_data <= buf_mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: doc/layer_y_rx_15_16.md
LAYER_Y_RX_15_16 -- requirements
Module: layer_y_rx_15_16

Interface
REQ-001 Parameters (one per line: name, default, meaning) SHALL be:
  WIDTH, 16, sample width, signed two's complement
  LEN, 15, samples per frame (conv layer output count)
  ADDR, 4, read-address width, 2^ADDR >= LEN
REQ-002 Ports SHALL be:
  clk  in  1  sole clock; all state changes on rising edge
  reset  in  1  asynchronous, active-low reset
  s_data_in_y  in  WIDTH  signed sample from upstream layer m_data_out_y
  s_valid_y  in  1  upstream sample valid
  s_ready_y  out  1  this block accepts a sample
  rd_addr  in  ADDR  buffer read address
  rd_data  out  WIDTH  signed buffer read data, registered
  frame_valid  out  1  complete frame held, buffer stable
  frame_done  out  1  one-cycle pulse, frame just completed
  max_val  out  WIDTH  signed maximum of held frame
  max_idx  out  ADDR  index of max_val
  release  in  1  consumer finished with held frame

Function
REQ-003 Block SHALL be the receiving end of a layer's y stream: transfer occurs in a cycle with s_valid_y=1 and s_ready_y=1, and only then.
REQ-004 FSM SHALL have two states: FILL (collect samples) and HOLD (frame held).
REQ-005 s_ready_y SHALL be 1 in FILL and 0 in HOLD, decoded from state only, with no dependence on s_valid_y.
REQ-006 Each transfer SHALL write s_data_in_y to buffer[idx] and increment idx (0..LEN-1).
REQ-007 A transfer with idx=LEN-1 SHALL move FILL->HOLD at that edge and reset idx to 0.
REQ-008 frame_done SHALL be 1 exactly in the first HOLD cycle, 0 otherwise.
REQ-009 frame_valid SHALL equal (state==HOLD).
REQ-010 In HOLD, release=1 SHALL move to FILL at the next edge; release in FILL SHALL be ignored.
REQ-011 A transfer SHALL be accepted in the first FILL cycle after release, giving zero bubble cycles beyond the single release cycle.
REQ-012 s_valid_y in HOLD SHALL cause no write, no idx change and no max update; upstream holds data by valid/ready rules.
REQ-013 Running max, on each transfer: sample at idx 0 SHALL load unconditionally into max_val/max_idx; a later sample SHALL replace them only if strictly greater (signed compare), so ties keep the lowest index.
REQ-014 max_val/max_idx SHALL hold their values through HOLD and are defined only while frame_valid=1.
REQ-015 rd_data SHALL be buffer[rd_addr] registered with 1-cycle latency, in any state.
REQ-016 rd_addr >= LEN SHALL return rd_data=0.
REQ-017 A read of the address written in the same cycle SHALL return the old contents.
REQ-018 No arithmetic beyond compare; no width growth; stored samples SHALL be bit-exact copies of s_data_in_y.

Reset
REQ-019 reset=0 SHALL asynchronously force: state=FILL, idx=0, s_ready_y=1, frame_valid=0, frame_done=0, max_val=0, max_idx=0, rd_data=0.
REQ-020 Buffer contents SHALL NOT be reset; reads before the first complete frame are undefined.
REQ-021 Reset asserted mid-frame SHALL discard the partial frame; after release of reset, the next transfer writes idx 0.
REQ-022 Reset deassertion SHALL be synchronized by the integrator; the block SHALL accept its first transfer on the first edge with reset=1.

Verification
REQ-023 Scenario, continuous stream: s_valid_y held 1 with samples 0..14 -> 15 transfers on consecutive cycles; frame_done pulses in the cycle after sample 14; s_ready_y=0; max_val=14, max_idx=14.
REQ-024 Scenario, backpressure and gaps: random s_valid_y gaps, then 3 extra valid cycles in HOLD -> buffer equals the first 15 accepted samples; extra samples not written; idx unchanged.
REQ-025 Scenario, signed max and tie: frame of -5,-3,-3 followed by twelve -100 values -> max_val=-3, max_idx=1; all-negative frame -> max is the largest negative, never 0.
REQ-026 Scenario, readback: in HOLD, sweep rd_addr 0..15 -> rd_data matches the samples with 1-cycle lag; addr 15 returns 0.
REQ-027 Scenario, release and back-to-back: release pulse for 1 cycle with s_valid_y=1 -> FILL in the next cycle, frame 2 accepted immediately, frame 2's max independent of frame 1.
REQ-028 Scenario, mid-frame reset: reset=0 after 7 transfers, then a full frame -> outputs at reset values during reset; the following frame completes after exactly 15 transfers.
